// File: rtl/udma_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX character port between NUM_REQ uDMA TX channels.
// Optional packet lock (hold grant until src_last_i) is enabled with `define UDMA_TX_ARB_LOCK_EN.
module udma_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    localparam int CHAN_W = $clog2(NUM_REQ)
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rst_i,
    input  logic [NUM_REQ-1:0]        src_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] src_data_i,
    input  logic [NUM_REQ-1:0]        src_last_i,
    output logic [NUM_REQ-1:0]        src_ready_o,
    input  logic                      data_tx_req_i,
    input  logic                      data_tx_ready_i,
    output logic                      data_tx_gnt_o,
    output logic [DATA_W-1:0]         data_tx_o,
    output logic                      data_tx_valid_o,
    output logic                      busy_o,
    output logic [CHAN_W-1:0]         cur_chan_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CHAN_W-1:0]   ptr_q;
    logic [CHAN_W-1:0]   ptr_next;
    logic [CHAN_W-1:0]   winner_q;
    logic [DATA_W-1:0]   data_q;
    logic [NUM_REQ-1:0]  eligible;
    logic                pick_found;
    logic [CHAN_W-1:0]   pick_idx;
    logic [CHAN_W:0]     idx_ext;
    logic [DATA_W-1:0]   sel_data;
    logic                start;

`ifdef UDMA_TX_ARB_LOCK_EN
    logic                lock_q;
    logic [CHAN_W-1:0]   lock_chan_q;

    // A granted word without the last flag pins arbitration to its channel.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
        end else if (state_q == S_GRANT) begin
            lock_q      <= ~src_last_i[winner_q];
            lock_chan_q <= winner_q;
        end
    end

    always_comb begin
        eligible = src_valid_i;
        if (lock_q) begin
            eligible              = '0;
            eligible[lock_chan_q] = src_valid_i[lock_chan_q];
        end
    end
`else
    logic unused_last;

    assign unused_last = ^src_last_i;
    assign eligible    = src_valid_i;
`endif

    // Search starts at the pointer and wraps; one extra bit keeps the sum from overflowing.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx_ext    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_ext = {1'b0, ptr_q} + (CHAN_W+1)'(i);
            if (idx_ext >= (CHAN_W+1)'(NUM_REQ))
                idx_ext = idx_ext - (CHAN_W+1)'(NUM_REQ);
            if (!pick_found && eligible[idx_ext[CHAN_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = idx_ext[CHAN_W-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (winner_q == CHAN_W'(i))
                sel_data = src_data_i[i*DATA_W +: DATA_W];
    end

    assign ptr_next = (winner_q == CHAN_W'(NUM_REQ-1)) ? '0 : winner_q + 1'b1;
    assign start    = data_tx_req_i && data_tx_ready_i && pick_found;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (state_q == S_IDLE && start)
                winner_q <= pick_idx;
            if (state_q == S_GRANT) begin
                data_q <= sel_data;
                ptr_q  <= ptr_next;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (latch).
        state_d         = state_q;
        data_tx_gnt_o   = 1'b0;
        data_tx_valid_o = 1'b0;
        src_ready_o     = '0;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_GRANT;
            end
            S_GRANT: begin
                data_tx_gnt_o         = 1'b1;
                src_ready_o[winner_q] = 1'b1;
                state_d               = S_DATA;
            end
            S_DATA: begin
                data_tx_valid_o = 1'b1;
                if (data_tx_ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_tx_o  = data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign cur_chan_o = winner_q;

endmodule

// File: tb/tb_udma_tx_arbiter.sv
// Directed self-checking bench for udma_tx_arbiter (NUM_REQ=4, DATA_W=32).
// Expected grant order of the packet test follows UDMA_TX_ARB_LOCK_EN when defined.
module tb_udma_tx_arbiter;

    logic         sys_clk_i = 1'b0;
    logic         sys_rst_i;
    logic [3:0]   src_valid_i;
    logic [127:0] src_data_i;
    logic [3:0]   src_last_i;
    logic [3:0]   src_ready_o;
    logic         data_tx_req_i;
    logic         data_tx_ready_i;
    logic         data_tx_gnt_o;
    logic [31:0]  data_tx_o;
    logic         data_tx_valid_o;
    logic         busy_o;
    logic [1:0]   cur_chan_o;

    int checks   = 0;
    int failures = 0;

    udma_tx_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .sys_clk_i       (sys_clk_i),
        .sys_rst_i       (sys_rst_i),
        .src_valid_i     (src_valid_i),
        .src_data_i      (src_data_i),
        .src_last_i      (src_last_i),
        .src_ready_o     (src_ready_o),
        .data_tx_req_i   (data_tx_req_i),
        .data_tx_ready_i (data_tx_ready_i),
        .data_tx_gnt_o   (data_tx_gnt_o),
        .data_tx_o       (data_tx_o),
        .data_tx_valid_o (data_tx_valid_o),
        .busy_o          (busy_o),
        .cur_chan_o      (cur_chan_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [31:0] val);
        src_data_i[ch*32 +: 32] = val;
    endtask

    logic [1:0]  exp_order [4];
    logic [31:0] exp_data  [4];
    int          ch1_cnt;

    initial begin
        // Reset state with requests pending but no source valid
        sys_rst_i       = 1'b1;
        src_valid_i     = 4'b0000;
        src_data_i      = '0;
        src_last_i      = 4'b0000;
        data_tx_req_i   = 1'b1;
        data_tx_ready_i = 1'b1;
        tick();
        check("rst_gnt",   32'(data_tx_gnt_o),   32'h0);
        check("rst_valid", 32'(data_tx_valid_o), 32'h0);
        check("rst_busy",  32'(busy_o),          32'h0);
        check("rst_ready", 32'(src_ready_o),     32'h0);
        check("rst_data",  data_tx_o,            32'h0);
        check("rst_chan",  32'(cur_chan_o),      32'h0);
        sys_rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_busy", 32'(busy_o),        32'h0);
            check("idle_gnt",  32'(data_tx_gnt_o), 32'h0);
        end

        // Single source on channel 2
        src_valid_i = 4'b0100;
        set_data(2, 32'h41);
        tick();
        check("single_gnt",   32'(data_tx_gnt_o),   32'h1);
        check("single_ready", 32'(src_ready_o),     32'h4);
        check("single_chan",  32'(cur_chan_o),      32'h2);
        check("single_novld", 32'(data_tx_valid_o), 32'h0);
        src_valid_i = 4'b0000;
        tick();
        check("single_valid", 32'(data_tx_valid_o), 32'h1);
        check("single_data",  data_tx_o,            32'h41);
        check("single_gnt0",  32'(data_tx_gnt_o),   32'h0);
        tick();
        check("single_idle",  32'(busy_o),          32'h0);
        check("single_vld0",  32'(data_tx_valid_o), 32'h0);

        // Round robin from a fresh pointer, all four channels valid
        sys_rst_i = 1'b1;
        #2;
        sys_rst_i = 1'b0;
        for (int n = 0; n < 4; n++) set_data(n, 32'h10 + 32'(n));
        src_valid_i = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            tick();
            check("rr_gnt",   32'(data_tx_gnt_o), 32'h1);
            check("rr_chan",  32'(cur_chan_o),    32'(w % 4));
            check("rr_ready", 32'(src_ready_o),   32'h1 << (w % 4));
            tick();
            check("rr_valid", 32'(data_tx_valid_o), 32'h1);
            check("rr_data",  data_tx_o,            32'h10 + 32'(w % 4));
            tick();
            check("rr_idle",  32'(busy_o),          32'h0);
            check("rr_vld0",  32'(data_tx_valid_o), 32'h0);
        end
        src_valid_i = 4'b0000;

        // Backpressure: pointer now at 1, channel 1 granted, ready held low 5 DATA cycles
        src_valid_i = 4'b0010;
        tick();
        check("bp_gnt",  32'(data_tx_gnt_o), 32'h1);
        check("bp_chan", 32'(cur_chan_o),    32'h1);
        data_tx_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", 32'(data_tx_valid_o), 32'h1);
            check("bp_data",  data_tx_o,            32'h11);
            check("bp_nognt", 32'(data_tx_gnt_o),   32'h0);
            check("bp_nordy", 32'(src_ready_o),     32'h0);
        end
        data_tx_ready_i = 1'b1;
        src_valid_i     = 4'b0000;
        tick();
        check("bp_idle",  32'(busy_o),          32'h0);
        check("bp_vld0",  32'(data_tx_valid_o), 32'h0);

        // Reset mid-transfer: pointer at 2, channel 2 in DATA when reset hits
        src_valid_i = 4'b0100;
        set_data(2, 32'h12);
        tick();
        check("mid_gnt", 32'(data_tx_gnt_o), 32'h1);
        data_tx_ready_i = 1'b0;
        src_valid_i     = 4'b0000;
        tick();
        check("mid_valid", 32'(data_tx_valid_o), 32'h1);
        #2;
        sys_rst_i = 1'b1;
        #1;
        check("mid_rst_valid", 32'(data_tx_valid_o), 32'h0);
        check("mid_rst_busy",  32'(busy_o),          32'h0);
        check("mid_rst_gnt",   32'(data_tx_gnt_o),   32'h0);
        check("mid_rst_data",  data_tx_o,            32'h0);
        tick();
        check("mid_rst_ready", 32'(src_ready_o), 32'h0);
        sys_rst_i       = 1'b0;
        data_tx_ready_i = 1'b1;
        src_valid_i     = 4'b1111;
        tick();
        check("post_rst_chan",  32'(cur_chan_o),  32'h0);
        check("post_rst_ready", 32'(src_ready_o), 32'h1);

        // Packet test: pointer now 1, ch0 always valid (last=1), ch1 sends 3 words last=0,0,1
        src_valid_i = 4'b0011;
        src_last_i  = 4'b0001;
        set_data(0, 32'h30);
        set_data(1, 32'h20);
        ch1_cnt = 0;
`ifdef UDMA_TX_ARB_LOCK_EN
        exp_order = '{2'd1, 2'd1, 2'd1, 2'd0};
        exp_data  = '{32'h20, 32'h21, 32'h22, 32'h30};
`else
        exp_order = '{2'd1, 2'd0, 2'd1, 2'd0};
        exp_data  = '{32'h20, 32'h30, 32'h21, 32'h30};
`endif
        tick();
        tick();
        for (int w = 0; w < 4; w++) begin
            tick();
            check("pkt_gnt",  32'(data_tx_gnt_o), 32'h1);
            check("pkt_chan", 32'(cur_chan_o),    32'(exp_order[w]));
            tick();
            check("pkt_data", data_tx_o, exp_data[w]);
            if (exp_order[w] == 2'd1) begin
                ch1_cnt++;
                set_data(1, 32'h20 + 32'(ch1_cnt));
                src_last_i[1] = (ch1_cnt == 2);
                if (ch1_cnt == 3) src_valid_i[1] = 1'b0;
            end
            tick();
            check("pkt_idle", 32'(busy_o), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
